eq_cmp_arbiter: RTL and testbench

Shares one 2-bit slice equality comparator between two requesters and sequences it over W-bit operands, two bits per cycle, with early termination on the first mismatching slice. Sits between two client blocks and the slice-compare datapath. Grants are round-robin. Each requester gets a grant pulse when its operands are latched and a done pulse carrying the equality result.

---
 rtl/eq_cmp_arbiter.sv | 105 ++++++++++
 tb/tb_eq_cmp_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/eq_cmp_arbiter.sv
// Round-robin arbiter in front of a shared 2-bit slice equality comparator.
// Each grant latches the winner's operands; slices are then compared LSB-first and the compare stops at the first mismatch.
module eq_cmp_arbiter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic         eq,
    output logic         busy
);
    localparam int S  = W / 2;
    localparam int IW = (S > 1) ? $clog2(S) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(S - 1);

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_owner;
    logic          r_last;
    logic          r_eq;
    logic [IW-1:0] r_idx;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;

    logic          w_any;
    logic          w_pick;
    logic          w_slice_eq;
    logic [W-1:0]  w_diff;

    assign w_any      = req0 | req1;
    // On a tie the requester that was not served last wins.
    assign w_pick     = (req0 & req1) ? ~r_last : req1;
    assign w_diff     = r_a ^ r_b;
    assign w_slice_eq = (w_diff[{r_idx, 1'b0} +: 2] == 2'b00);

    // NOTE: next state gets a default before the case so no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = CMP;
            CMP:     if (!w_slice_eq || (r_idx == LAST_IDX)) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_eq    <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_owner <= w_pick;
                        r_idx   <= '0;
                    end
                end
                CMP: begin
                    if (!w_slice_eq) begin
                        r_eq <= 1'b0;
                    end else if (r_idx == LAST_IDX) begin
                        r_eq <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE:    r_last <= r_owner;
                default: ;
            endcase
        end
    end

    // NOTE: operand registers carry no reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        if ((r_state == IDLE) && w_any) begin
            r_a <= w_pick ? a1 : a0;
            r_b <= w_pick ? b1 : b0;
        end
    end

    // The CMP cycle at slice 0 occurs exactly once per grant, so it doubles as the grant pulse.
    assign gnt0  = (r_state == CMP) && (r_idx == '0) && !r_owner;
    assign gnt1  = (r_state == CMP) && (r_idx == '0) &&  r_owner;
    assign done0 = (r_state == DONE) && !r_owner;
    assign done1 = (r_state == DONE) &&  r_owner;
    assign eq    = r_eq;
    assign busy  = (r_state != IDLE);

endmodule

// File: tb/tb_eq_cmp_arbiter.sv
// Self-checking bench for eq_cmp_arbiter at W=2, 8 and 16 sharing one stimulus.
// Expected timing comes from a per-transaction slice-count model.
module tb_eq_cmp_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req0;
    logic        req1;
    logic [15:0] a0;
    logic [15:0] b0;
    logic [15:0] a1;
    logic [15:0] b1;

    // Instance index 0: W=2, 1: W=8, 2: W=16
    logic [2:0] gnt0_v, gnt1_v, done0_v, done1_v, eq_v, busy_v;
    logic [4:0] st [3];
    int         wd [3] = '{2, 8, 16};

    eq_cmp_arbiter #(.W(2)) u_w2 (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .a0(a0[1:0]), .b0(b0[1:0]), .a1(a1[1:0]), .b1(b1[1:0]),
        .gnt0(gnt0_v[0]), .gnt1(gnt1_v[0]), .done0(done0_v[0]), .done1(done1_v[0]),
        .eq(eq_v[0]), .busy(busy_v[0])
    );
    eq_cmp_arbiter #(.W(8)) u_w8 (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .a0(a0[7:0]), .b0(b0[7:0]), .a1(a1[7:0]), .b1(b1[7:0]),
        .gnt0(gnt0_v[1]), .gnt1(gnt1_v[1]), .done0(done0_v[1]), .done1(done1_v[1]),
        .eq(eq_v[1]), .busy(busy_v[1])
    );
    eq_cmp_arbiter #(.W(16)) u_w16 (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0_v[2]), .gnt1(gnt1_v[2]), .done0(done0_v[2]), .done1(done1_v[2]),
        .eq(eq_v[2]), .busy(busy_v[2])
    );

    assign st[0] = {gnt0_v[0], gnt1_v[0], done0_v[0], done1_v[0], busy_v[0]};
    assign st[1] = {gnt0_v[1], gnt1_v[1], done0_v[1], done1_v[1], busy_v[1]};
    assign st[2] = {gnt0_v[2], gnt1_v[2], done0_v[2], done1_v[2], busy_v[2]};

    typedef struct {
        logic        r0;
        logic        r1;
        logic [15:0] a0;
        logic [15:0] b0;
        logic [15:0] a1;
        logic [15:0] b1;
        logic        own;
        int          k8;
        logic        eq8;
    } vec_t;

    vec_t tbl [8];
    int   n_err = 0;
    int   n_chk = 0;
    logic m_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slices examined before the compare resolves: first mismatching slice + 1, or all of them.
    function automatic int first_k(input logic [15:0] a, input logic [15:0] b, input int w);
        for (int j = 0; j < w / 2; j++)
            if (((a >> (2 * j)) & 16'h3) != ((b >> (2 * j)) & 16'h3)) return j + 1;
        return w / 2;
    endfunction

    function automatic logic ref_eq(input logic [15:0] a, input logic [15:0] b, input int w);
        logic [31:0] mask;
        mask = (32'h1 << w) - 32'h1;
        return ({16'h0, a} & mask) == ({16'h0, b} & mask);
    endfunction

    // Expected {gnt0,gnt1,done0,done1,busy} in cycle Cc after the grant edge.
    function automatic logic [4:0] exp_st(input int c, input logic o, input int k);
        return {(c == 1) && !o, (c == 1) && o, (c == k + 1) && !o, (c == k + 1) && o, (c <= k + 1)};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset w%0d outputs", wd[d]), 32'(st[d]), 32'h0);
            check($sformatf("reset w%0d eq", wd[d]), 32'(eq_v[d]), 32'h0);
        end
        @(negedge clk);
        reset  = 1'b0;
        m_last = 1'b1;
    endtask

    // One request pulse sampled at E0, then operands scrambled and C1..C10 checked on every instance.
    task automatic run_txn(input string tag, input logic r0, input logic r1,
                           input logic [15:0] xa0, input logic [15:0] xb0,
                           input logic [15:0] xa1, input logic [15:0] xb1,
                           input logic o, input int k8, input logic e8);
        int          k [3];
        logic        e [3];
        logic [15:0] ao, bo;
        ao   = o ? xa1 : xa0;
        bo   = o ? xb1 : xb0;
        k[0] = first_k(ao, bo, 2);
        e[0] = ref_eq(ao, bo, 2);
        k[1] = k8;
        e[1] = e8;
        k[2] = first_k(ao, bo, 16);
        e[2] = ref_eq(ao, bo, 16);
        req0 = r0; req1 = r1;
        a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1;
        @(posedge clk);
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        a0 = 16'($urandom); b0 = 16'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
        for (int c = 1; c <= 10; c++) begin
            for (int d = 0; d < 3; d++) begin
                check($sformatf("%s w%0d C%0d outputs", tag, wd[d], c), 32'(st[d]), 32'(exp_st(c, o, k[d])));
                if (c > k[d])
                    check($sformatf("%s w%0d C%0d eq", tag, wd[d], c), 32'(eq_v[d]), 32'(e[d]));
            end
            @(negedge clk);
        end
        m_last = o;
    endtask

    initial begin
        logic        o;
        logic [1:0]  r;
        logic [15:0] ra0, rb0, ra1, rb1;

        tbl[0] = '{1'b1, 1'b0, 16'h00A5, 16'h00A5, 16'h0000, 16'h0000, 1'b0, 4, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 1'b1, 1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0080, 16'h0000, 1'b1, 4, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 16'h003C, 16'h003C, 16'h0000, 16'h000C, 1'b0, 4, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 16'h0000, 16'h0030, 16'h00FF, 16'h00FF, 1'b1, 4, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 16'h0012, 16'h0016, 16'h0000, 16'h0000, 1'b0, 2, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 16'h0055, 16'h0055, 16'h0040, 16'h0000, 1'b1, 4, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 16'h12C3, 16'h34C3, 16'h0000, 16'h0000, 1'b0, 4, 1'b1};

        reset = 1'b1;
        req0  = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        do_reset();

        for (int i = 0; i < 8; i++)
            run_txn($sformatf("vec%0d", i), tbl[i].r0, tbl[i].r1, tbl[i].a0, tbl[i].b0,
                    tbl[i].a1, tbl[i].b1, tbl[i].own, tbl[i].k8, tbl[i].eq8);

        // Both requests held: W=8 grants alternate every k+2 = 6 cycles.
        o    = ~m_last;
        req0 = 1'b1; req1 = 1'b1;
        a0 = 16'hA5A5; b0 = 16'hA5A5; a1 = 16'hA5A5; b1 = 16'hA5A5;
        @(posedge clk);
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            check($sformatf("contend C%0d outputs", c), 32'(st[1]),
                  32'(exp_st((c - 1) % 6 + 1, o ^ 1'(((c - 1) / 6) & 1), 4)));
            if ((c - 1) % 6 == 4)
                check($sformatf("contend C%0d eq", c), 32'(eq_v[1]), 32'h1);
        end
        req0 = 1'b0; req1 = 1'b0;
        do_reset();

        // Reset during CMP at slice 2 abandons the compare.
        req0 = 1'b1;
        a0 = 16'hFFFF; b0 = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        req0 = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            check($sformatf("abort C%0d outputs", c), 32'(st[1]), 32'(exp_st(c, 1'b0, 4)));
            if (c < 3) @(negedge clk);
        end
        #2 reset = 1'b1;
        #1;
        for (int d = 0; d < 3; d++)
            check($sformatf("abort w%0d async outputs", wd[d]), 32'(st[d]), 32'h0);
        @(negedge clk);
        check("abort held outputs", 32'(st[1]), 32'h0);
        check("abort held eq", 32'(eq_v[1]), 32'h0);
        reset  = 1'b0;
        m_last = 1'b1;
        run_txn("rearm", 1'b1, 1'b1, 16'h00A5, 16'h00A5, 16'h0000, 16'h0000, 1'b0, 4, 1'b1);

        for (int i = 0; i < 40; i++) begin
            r   = 2'($urandom_range(1, 3));
            ra0 = 16'($urandom);
            ra1 = 16'($urandom);
            rb0 = ra0;
            rb1 = ra1;
            if ($urandom_range(0, 2) != 0) rb0 = rb0 ^ (16'h1 << $urandom_range(0, 15));
            if ($urandom_range(0, 2) != 0) rb1 = rb1 ^ (16'h1 << $urandom_range(0, 15));
            o = (r[0] && r[1]) ? ~m_last : r[1];
            run_txn($sformatf("rnd%0d", i), r[0], r[1], ra0, rb0, ra1, rb1, o,
                    first_k(o ? ra1 : ra0, o ? rb1 : rb0, 8),
                    ref_eq(o ? ra1 : ra0, o ? rb1 : rb0, 8));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
